// File: rtl/fifo_rr_scheduler.sv
// Round-robin mover from four input FIFOs to four output FIFOs, routing each
// word by its destination field and holding it while the target FIFO pauses.
module fifo_rr_scheduler #(
    parameter int DATA_WIDTH = 6,
    parameter int READ_LAT   = 2,
    parameter int DEST_LSB   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [3:0]                in_empty,
    input  logic [4*DATA_WIDTH-1:0]   in_data,
    output logic [3:0]                in_pop,
    input  logic [3:0]                out_pause,
    output logic [3:0]                out_push,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [1:0]                grant,
    output logic                      busy,
    output logic [7:0]                word_count
);

    localparam int CNT_W = 3;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_POP      = 2'd1;
    localparam logic [1:0] S_WAIT     = 2'd2;
    localparam logic [1:0] S_DISPATCH = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            r_grant;
    logic [1:0]            r_last_grant;
    logic [3:0]            r_in_pop;
    logic                  r_busy;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [7:0]            r_word_count;

    logic [1:0]            w_state_next;
    logic [DATA_WIDTH-1:0] w_word [4];
    logic [1:0]            w_cand_idx [4];
    logic [3:0]            w_cand_ok;
    logic [1:0]            w_pick;
    logic                  w_pick_valid;
    logic                  w_start;
    logic [1:0]            w_dest;
    logic [3:0]            w_push_vec;
    logic                  w_push_fire;

    assign w_dest = r_data[DEST_LSB+1:DEST_LSB];

    // Candidate gi is the input gi+1 positions after the last served one.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_word[gi]     = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_cand_idx[gi] = r_last_grant + 2'(gi + 1);
            assign w_cand_ok[gi]  = ~in_empty[w_cand_idx[gi]];
            assign w_push_vec[gi] = (r_state == S_DISPATCH) && (w_dest == 2'(gi))
                                    && ~out_pause[gi];
        end
    endgenerate

    always_comb begin
        w_pick       = r_last_grant;
        w_pick_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (w_cand_ok[k]) begin
                w_pick       = w_cand_idx[k];
                w_pick_valid = 1'b1;
            end
        end
    end

    assign w_start     = (r_state == S_IDLE) && enable && w_pick_valid;
    assign w_push_fire = |w_push_vec;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (w_start) w_state_next = S_POP;
            S_POP:      w_state_next = S_WAIT;
            S_WAIT:     if (r_wait_cnt == '0) w_state_next = S_DISPATCH;
            S_DISPATCH: if (w_push_fire) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant      <= 2'd0;
            r_last_grant <= 2'd3;
            r_in_pop     <= 4'd0;
            r_busy       <= 1'b0;
            r_wait_cnt   <= '0;
            r_data       <= '0;
            r_word_count <= 8'd0;
        end else begin
            r_state  <= w_state_next;
            r_busy   <= (w_state_next != S_IDLE);
            r_in_pop <= 4'd0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_grant  <= w_pick;
                        r_in_pop <= 4'b0001 << w_pick;
                    end
                end
                S_POP: begin
                    r_wait_cnt <= CNT_W'(READ_LAT - 1);
                end
                S_WAIT: begin
                    // Counter reaches zero in the cycle the FIFO word is valid.
                    if (r_wait_cnt == '0) begin
                        r_data <= w_word[r_grant];
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                S_DISPATCH: begin
                    if (w_push_fire) begin
                        r_word_count <= r_word_count + 8'd1;
                        r_last_grant <= r_grant;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_pop     = r_in_pop;
    assign out_push   = w_push_vec;
    assign out_data   = r_data;
    assign grant      = r_grant;
    assign busy       = r_busy;
    assign word_count = r_word_count;

endmodule
